// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect/flush controls, instruction memory port and downstream instruction port.
// Carries misalign only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_unit_if;
    logic        ctrlFetch;
    logic [31:0] newPC;
    logic        global_reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    modport master (
        input  ctrlFetch, newPC, global_reset, imem_ack, imem_data, inst_ready,
        output imem_req, imem_addr, inst, inst_pc, inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    modport slave (
        output ctrlFetch, newPC, global_reset, imem_ack, imem_data, inst_ready,
        input  imem_req, imem_addr, inst, inst_pc, inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
        , input misalign
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding memory read FSM and a 2-entry {pc, inst} buffer.
// Optional FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap (misalign output, HALT state).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    // state | meaning
    // IDLE  | no request outstanding
    // WAIT  | request outstanding, data will be buffered
    // DROP  | request outstanding, data will be discarded
    // HALT  | misaligned redirect trapped, no fetching (trap build only)
`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;
`endif

    state_t      state_q, state_d, rest_st;
    logic [31:0] pc_q, pc_d, pc_inc;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ent_pc_q   [2];
    logic [31:0] ent_inst_q [2];
    logic        rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        flush, pop, push, wr_idx, head_valid;
    logic [31:0] target;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;

    assign target       = bus.newPC;
    assign bus.misalign = misalign_q;
`else
    assign target = bus.newPC & 32'hFFFF_FFFC;
`endif

    assign head_valid = (cnt_q != 2'd0);
    assign flush      = bus.ctrlFetch | bus.global_reset;
    assign pop        = head_valid & bus.inst_ready;
    assign push       = (state_q == ST_WAIT) & bus.imem_ack & ~flush;
    assign wr_idx     = rd_q ^ cnt_q[0];
    assign pc_inc     = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        rest_st = ST_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif

        if (flush) begin
            cnt_d = 2'd0;
        end else if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
        if (pop && !flush) begin
            rd_d = ~rd_q;
        end

        if (push) begin
            pc_d = pc_inc;
        end
        if (bus.ctrlFetch) begin
            pc_d = target;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_d = (bus.newPC[1:0] != 2'b00);
`endif
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_d) begin
            rest_st = ST_HALT;
        end
`endif

        // Space is judged on the post-push/pop count so a request never overfills the buffer.
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = rest_st;
                end else if (cnt_d != 2'd2) begin
                    state_d = ST_WAIT;
                    addr_d  = pc_q;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = bus.imem_ack ? rest_st : ST_DROP;
                end else if (bus.imem_ack) begin
                    if (cnt_d != 2'd2) begin
                        addr_d = pc_inc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (bus.imem_ack) begin
                    state_d = rest_st;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                if (bus.ctrlFetch) begin
                    state_d = rest_st;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            cnt_q   <= 2'd0;
            rd_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]   <= 32'd0;
                ent_inst_q[i] <= 32'd0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            if (push) begin
                ent_pc_q[wr_idx]   <= addr_q;
                ent_inst_q[wr_idx] <= bus.imem_data;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign bus.imem_req   = (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = ent_inst_q[rd_q];
    assign bus.inst_pc    = ent_pc_q[rd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of the instruction stream plus directed scenarios.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(RESET_PC)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: acks after the request has been held for 'lat' cycles; never acks stall_addr.
    int          lat        = 0;
    int          age        = 0;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    logic        raw_ack    = 1'b0;
    logic        req_s      = 1'b0;
    logic        ack_s      = 1'b0;

    assign bus.imem_ack  = raw_ack && bus.imem_req && (bus.imem_addr != stall_addr);
    assign bus.imem_data = mem_fn(bus.imem_addr);

    always @(negedge clock) begin
        req_s = bus.imem_req;
        ack_s = bus.imem_ack;
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (!req_s || ack_s) age = 0;
        else age = age + 1;
        raw_ack = (age >= lat);
    end

    // Reference model: expected buffer contents, next fetch address, one tracked outstanding request.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    ent_t        acc_q[$];
    logic [31:0] exp_pc     = RESET_PC;
    logic [31:0] out_addr   = '0;
    bit          out_active = 1'b0;
    bit          out_drop   = 1'b0;
    bit          halted     = 1'b0;

    always @(negedge clock) begin : compare
        logic flush;
        ent_t e;
        if (!reset) begin
            mq.delete();
            out_active = 1'b0;
            out_drop   = 1'b0;
            halted     = 1'b0;
            exp_pc     = RESET_PC;
            chk_eq("rst_imem_req", bus.imem_req, 0);
            chk_eq("rst_imem_addr", bus.imem_addr, RESET_PC);
            chk_eq("rst_inst_valid", bus.inst_valid, 0);
            chk_eq("rst_inst", bus.inst, 0);
            chk_eq("rst_inst_pc", bus.inst_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk_eq("rst_misalign", bus.misalign, 0);
`endif
        end else begin
            chk_eq("head_valid", bus.inst_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk_eq("head_pc", bus.inst_pc, mq[0].pc);
                chk_eq("head_inst", bus.inst, mq[0].ins);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            chk_eq("misalign", bus.misalign, halted);
`endif
            if (bus.imem_req) begin
                if (out_active) begin
                    chk_eq("req_stable", bus.imem_addr, out_addr);
                end else begin
                    chk_eq("req_addr", bus.imem_addr, exp_pc);
                    chk_eq("req_room", (mq.size() < 2), 1);
                    chk_eq("req_while_halted", halted, 0);
                    out_active = 1'b1;
                    out_drop   = 1'b0;
                    out_addr   = bus.imem_addr;
                end
            end else if (out_active) begin
                chk_eq("req_abandoned", 0, 1);
                out_active = 1'b0;
            end

            if (bus.inst_valid && bus.inst_ready) begin
                e.pc  = bus.inst_pc;
                e.ins = bus.inst;
                acc_q.push_back(e);
            end

            flush = bus.ctrlFetch | bus.global_reset;
            if (mq.size() != 0 && bus.inst_ready) mq.pop_front();
            if (bus.imem_ack && out_active) begin
                if (!out_drop && !flush) begin
                    e.pc  = out_addr;
                    e.ins = mem_fn(out_addr);
                    mq.push_back(e);
                    exp_pc = exp_pc + 32'd4;
                end
                out_active = 1'b0;
            end
            if (flush) begin
                mq.delete();
                if (out_active) out_drop = 1'b1;
            end
            if (bus.ctrlFetch) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                halted = (bus.newPC[1:0] != 2'b00);
                exp_pc = bus.newPC;
`else
                exp_pc = bus.newPC & 32'hFFFF_FFFC;
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic rdy, input int l);
        reset            = 1'b0;
        bus.ctrlFetch    = 1'b0;
        bus.global_reset = 1'b0;
        bus.newPC        = 32'd0;
        bus.inst_ready   = rdy;
        lat              = l;
        stall_addr       = 32'hFFFF_FFFF;
        cyc(3);
        reset = 1'b1;
        acc_q.delete();
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_q.size() < n && k < 100) begin
            @(negedge clock);
            #1;
            k++;
        end
        chk_eq(name, (acc_q.size() >= n), 1);
    endtask

    task automatic next_req(input logic [31:0] old, input logic [31:0] exp, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            #1;
            if (bus.imem_req && bus.imem_addr != old) begin
                found = 1'b1;
                chk_eq(name, bus.imem_addr, exp);
            end
        end
        if (!found) chk_eq({name, "_timeout"}, 0, 1);
    endtask

    task automatic first_req(input logic [31:0] exp, input string name);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clock);
            #1;
            if (bus.imem_req) begin
                found = 1'b1;
                chk_eq(name, bus.imem_addr, exp);
            end
        end
        if (!found) chk_eq({name, "_timeout"}, 0, 1);
    endtask

    logic [31:0] lit_pc  [4];
    logic [31:0] lit_ins [4];

    initial begin
        int nb;
        int seen8;
        bit found;
        lit_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
        lit_ins = '{32'hFFFF_0000, 32'hFFFB_0004, 32'hFFF7_0008, 32'hFFF3_000C};
        bus.ctrlFetch    = 1'b0;
        bus.global_reset = 1'b0;
        bus.newPC        = 32'd0;
        bus.inst_ready   = 1'b0;

        // Straight-line fetch, single-cycle memory, always ready
        do_reset(1'b1, 0);
        wait_acc(4, "seq_count");
        for (int i = 0; i < 4; i++) begin
            chk_eq("seq_pc", (i < acc_q.size()) ? acc_q[i].pc : 32'hx, lit_pc[i]);
            chk_eq("seq_inst", (i < acc_q.size()) ? acc_q[i].ins : 32'hx, lit_ins[i]);
        end

        // Back-pressure: two entries buffered, no request, then drain in order
        do_reset(1'b0, 1);
        cyc(12);
        repeat (5) begin
            @(negedge clock);
            chk_eq("full_noreq", bus.imem_req, 0);
        end
        chk_eq("full_valid", bus.inst_valid, 1);
        chk_eq("full_head_pc", bus.inst_pc, 32'h0);
        cyc(1);
        bus.inst_ready = 1'b1;
        next_req(32'h4, 32'h8, "drain_next_addr");
        wait_acc(2, "drain_count");
        chk_eq("drain_pc0", (acc_q.size() > 0) ? acc_q[0].pc : 32'hx, 32'h0);
        chk_eq("drain_pc1", (acc_q.size() > 1) ? acc_q[1].pc : 32'hx, 32'h4);

        // Redirect while the request to 0x8 is outstanding
        do_reset(1'b1, 3);
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clock);
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
        end
        chk_eq("reach_req8", found, 1);
        cyc(1);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h100;
        nb = acc_q.size();
        cyc(1);
        bus.ctrlFetch = 1'b0;
        next_req(32'h8, 32'h100, "redirect_addr");
        wait_acc(nb + 1, "redirect_count");
        chk_eq("redirect_first_pc", (acc_q.size() > nb) ? acc_q[nb].pc : 32'hx, 32'h100);
        seen8 = 0;
        foreach (acc_q[i]) if (acc_q[i].pc == 32'h8) seen8++;
        chk_eq("no_0x8_output", seen8, 0);

        // global_reset alone with two entries, then combined flush with a pop
        do_reset(1'b0, 0);
        cyc(8);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h8;
        cyc(1);
        bus.ctrlFetch = 1'b0;
        cyc(8);
        chk_eq("gr_pre_valid", bus.inst_valid, 1);
        chk_eq("gr_pre_pc", bus.inst_pc, 32'h8);
        chk_eq("gr_pre_inst", bus.inst, 32'hFFF7_0008);
        bus.global_reset = 1'b1;
        cyc(1);
        bus.global_reset = 1'b0;
        chk_eq("gr_valid", bus.inst_valid, 0);
        next_req(32'hC, 32'h10, "gr_next_addr");
        cyc(8);
        chk_eq("refill_pc", bus.inst_pc, 32'h10);
        bus.inst_ready   = 1'b1;
        bus.ctrlFetch    = 1'b1;
        bus.global_reset = 1'b1;
        bus.newPC        = 32'h40;
        cyc(1);
        bus.inst_ready   = 1'b0;
        bus.ctrlFetch    = 1'b0;
        bus.global_reset = 1'b0;
        chk_eq("flush_pop_empty", bus.inst_valid, 0);
        next_req(32'h14, 32'h40, "both_next_addr");

        // Asynchronous reset in the middle of an outstanding request
        do_reset(1'b0, 0);
        stall_addr = 32'h20;
        cyc(8);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h1C;
        cyc(1);
        bus.ctrlFetch = 1'b0;
        cyc(6);
        chk_eq("midwait_req", bus.imem_req, 1);
        chk_eq("midwait_addr", bus.imem_addr, 32'h20);
        chk_eq("midwait_head", bus.inst_pc, 32'h1C);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk_eq("async_req", bus.imem_req, 0);
        chk_eq("async_addr", bus.imem_addr, RESET_PC);
        chk_eq("async_valid", bus.inst_valid, 0);
        chk_eq("async_inst", bus.inst, 0);
        chk_eq("async_inst_pc", bus.inst_pc, 0);
        stall_addr = 32'hFFFF_FFFF;
        cyc(2);
        reset = 1'b1;
        first_req(RESET_PC, "post_reset_first");

        // Misaligned redirect target
        do_reset(1'b0, 0);
        cyc(8);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h102;
        cyc(1);
        bus.ctrlFetch = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk_eq("trap_misalign", bus.misalign, 1);
        repeat (8) begin
            @(negedge clock);
            chk_eq("trap_noreq", bus.imem_req, 0);
        end
        cyc(1);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h200;
        cyc(1);
        bus.ctrlFetch = 1'b0;
        chk_eq("trap_cleared", bus.misalign, 0);
        next_req(32'h4, 32'h200, "trap_exit_addr");
`else
        next_req(32'h4, 32'h100, "misalign_mask_addr");
`endif

        // Redirect while discarding an outstanding request
        do_reset(1'b1, 0);
        stall_addr = 32'h8;
        cyc(10);
        chk_eq("drop_pre_req", bus.imem_req, 1);
        chk_eq("drop_pre_addr", bus.imem_addr, 32'h8);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h300;
        cyc(1);
        bus.ctrlFetch = 1'b0;
        cyc(2);
        bus.ctrlFetch = 1'b1;
        bus.newPC     = 32'h400;
        cyc(1);
        bus.ctrlFetch = 1'b0;
        cyc(2);
        chk_eq("drop_stable_req", bus.imem_req, 1);
        chk_eq("drop_stable_addr", bus.imem_addr, 32'h8);
        stall_addr = 32'hFFFF_FFFF;
        next_req(32'h8, 32'h400, "drop_redirect_addr");
        cyc(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clock  input  1  single clock; all state updates on posedge clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: ctrlFetch  input  1  redirect strobe from the jump unit; load newPC.
REQ-005 Port: newPC  input  32  redirect target, valid when ctrlFetch=1.
REQ-006 Port: global_reset  input  1  pipeline flush from the jump unit.
REQ-007 Port: imem_req  output  1  instruction memory read request.
REQ-008 Port: imem_addr  output  32  instruction memory read address.
REQ-009 Port: imem_ack  input  1  read complete; imem_data valid this cycle.
REQ-010 Port: imem_data  input  32  instruction word returned by memory.
REQ-011 Port: inst  output  32  instruction word presented downstream, from the buffer head.
REQ-012 Port: inst_pc  output  32  address of inst.
REQ-013 Port: inst_valid  output  1  buffer head holds a valid entry.
REQ-014 Port: inst_ready  input  1  downstream accepts the head this cycle.

Function
REQ-015 The block SHALL hold a fetch PC register; each completed, non-discarded read SHALL advance it by 4, modulo 2^32.
REQ-016 The block SHALL contain a 2-entry FIFO of {pc, inst}; inst, inst_pc, and inst_valid SHALL reflect the FIFO head.
REQ-017 The FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding), and DROP (outstanding request to be discarded).
REQ-018 A request SHALL be issued only when the FIFO count plus outstanding requests is less than 2: IDLE->WAIT, imem_req=1, imem_addr=PC.
REQ-019 imem_req and imem_addr SHALL remain stable in WAIT/DROP until imem_ack is sampled high.
REQ-020 In WAIT, imem_ack SHALL push {imem_addr, imem_data} and advance PC. If space remains, the FSM SHALL stay in WAIT with the next address in the following cycle; otherwise it SHALL go to IDLE.
REQ-021 A pop SHALL occur when inst_valid and inst_ready are both 1 at a posedge. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-022 ctrlFetch=1 SHALL load PC<=newPC and empty the FIFO. An outstanding request SHALL move the FSM to DROP; otherwise the FSM SHALL go to IDLE.
REQ-023 global_reset=1 SHALL empty the FIFO and discard any outstanding request via DROP; PC SHALL be unchanged unless ctrlFetch is also 1.
REQ-024 ctrlFetch and global_reset in the same cycle SHALL give one flush with PC=newPC.
REQ-025 In DROP, imem_ack SHALL be consumed with no push and no PC change, and the FSM SHALL go to IDLE. A redirect in DROP SHALL update PC and stay in DROP.
REQ-026 A redirect coinciding with imem_ack in WAIT SHALL discard the returned data and go to IDLE with PC=newPC.
REQ-027 A flush coinciding with a pop SHALL leave the FIFO empty.
REQ-028 First redirected instruction latency: request issued the cycle after ctrlFetch, and inst_valid asserted the cycle after imem_ack.

Reset
REQ-029 While reset=0, and asynchronously on its assertion, the block SHALL set PC=RESET_PC, state=IDLE, FIFO empty, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, and inst_pc=0.
REQ-030 The first request SHALL issue in the first clock cycle after reset deasserts.
REQ-031 Reset asserted during WAIT SHALL abandon the request; a late imem_ack after reset SHALL be ignored because imem_req=0.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN, when defined, SHALL add output misalign (1 bit, reset 0) and state HALT.
- Redirect with newPC[1:0]!=0: misalign=1, FIFO flushed, FSM to HALT (or DROP then HALT), no further requests.
- Exit HALT only on an aligned redirect (clears misalign) or reset.
REQ-033 When FETCH_MISALIGN_TRAP_EN is undefined, PC SHALL load {newPC[31:2],2'b00}, and neither misalign nor HALT SHALL exist.

Verification
REQ-034 Reset release, memory acks in 1 cycle, inst_ready=1 -> inst_pc sequence 0,4,8,C with matching imem_data.
REQ-035 inst_ready=0 with acks 1 cycle after each request -> exactly 2 entries buffered, imem_req stays 0, PC=8; ready=1 -> entries 0,4 drain in order.
REQ-036 ctrlFetch=1, newPC=0x100, while a request to 0x8 is outstanding (ack 3 cycles later) -> the 0x8 data is never output, and the next request address is 0x100.
REQ-037 global_reset=1 alone with 2 entries buffered and PC=0x10 -> inst_valid=0 next cycle, and the next request address is 0x10.
REQ-038 Reset driven low mid-WAIT at PC=0x20 -> all outputs return to reset values immediately, and after release the first request is to RESET_PC.
REQ-039 With FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 -> misalign=1 and no request; a subsequent redirect to 0x200 -> misalign=0 and a request to 0x200.
